// File: rtl/core_pkg.sv
// Shared types for the 5-stage core's hazard/forwarding logic: forward select codes,
// sequencer states and the destination scoreboard entry.
package core_pkg;

  localparam int REG_AW = 3;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_ALU = 2'd1,
    FWD_MEM = 2'd2,
    FWD_WB  = 2'd3
  } fwd_sel_e;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LDSTALL = 2'd1,
    MWAIT   = 2'd2,
    FLUSH   = 2'd3
  } hz_state_e;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              wr;
    logic              load;
  } sb_entry_t;

  // A slot can supply a source only if it really writes that register; R0 is hardwired zero.
  function automatic logic sb_hit(input sb_entry_t e, input logic [REG_AW-1:0] src,
                                  input logic uses);
    return e.valid && e.wr && (e.rd == src) && (src != '0) && uses;
  endfunction

endpackage

// File: rtl/hazard_forward_ctrl_fwd_select.sv
// One operand's forward select: youngest matching scoreboard slot wins.
// Also flags a hit on the EX slot when that slot is a load (load-use hazard).
module fwd_select
  import core_pkg::*;
(
  input  sb_entry_t         ex_e,
  input  sb_entry_t         mem_e,
  input  sb_entry_t         wb_e,
  input  logic [REG_AW-1:0] src,
  input  logic              uses,
  output fwd_sel_e          sel,
  output logic              ex_load_hit
);

  logic hit_ex, hit_mem, hit_wb;

  always_comb begin
    hit_ex  = sb_hit(ex_e, src, uses);
    hit_mem = sb_hit(mem_e, src, uses);
    hit_wb  = sb_hit(wb_e, src, uses);
    sel     = FWD_RF;
    if (hit_ex)       sel = FWD_ALU;
    else if (hit_mem) sel = FWD_MEM;
    else if (hit_wb)  sel = FWD_WB;
  end

  assign ex_load_hit = hit_ex & ex_e.load;

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Pipeline sequencer: EX/MEM/WB destination scoreboard, operand forward selects,
// load-use stall, memory-wait freeze and post-redirect fetch flush.
module hazard_forward_ctrl
  import core_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_ra,
  input  logic [REG_AW-1:0] id_rb,
  input  logic              id_uses_a,
  input  logic              id_uses_b,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_is_load,
  input  logic              id_redirect,
  input  logic              mem_busy,
  output logic [1:0]        forward_a,
  output logic [1:0]        forward_b,
  output logic              stall,
  output logic              bubble_ex,
  output logic              flush_if,
  output logic [CNT_W-1:0]  stall_count
);

  localparam int FC_W = 2;

  // Slot 0 = EX, 1 = MEM, 2 = WB.
  sb_entry_t [2:0]        sb_q, sb_d;
  hz_state_e              state_q, state_d;
  logic [FC_W-1:0]        fcnt_q, fcnt_d;
  logic [CNT_W-1:0]       stall_count_q, stall_count_d;

  logic [1:0][REG_AW-1:0] src;
  logic [1:0]             uses;
  logic [1:0]             ld_hit;
  fwd_sel_e               sel [2];
  logic                   load_use;
  logic                   stall_c, bubble_c, flush_c;

  assign src  = {id_rb, id_ra};
  assign uses = {id_uses_b, id_uses_a};

  for (genvar g = 0; g < 2; g++) begin : g_op
    fwd_select u_fwd (
      .ex_e        (sb_q[0]),
      .mem_e       (sb_q[1]),
      .wb_e        (sb_q[2]),
      .src         (src[g]),
      .uses        (uses[g]),
      .sel         (sel[g]),
      .ex_load_hit (ld_hit[g])
    );
  end

  assign forward_a = sel[0];
  assign forward_b = sel[1];
  assign load_use  = |ld_hit;

  // RUN, LDSTALL and MWAIT share one decision: the cycle mem_busy drops the decode slot
  // advances, so its load-use and redirect must be handled exactly as in RUN. The state
  // label still records why the previous cycle stalled. A redirect on the retried decode
  // after a load-use stall is therefore honoured from LDSTALL.
  always_comb begin
    state_d  = state_q;
    fcnt_d   = fcnt_q;
    stall_c  = 1'b0;
    bubble_c = 1'b0;
    flush_c  = 1'b0;
    unique case (state_q)
      FLUSH: begin
        flush_c = 1'b1;
        stall_c = mem_busy;
        if (!mem_busy) begin
          if (fcnt_q == FC_W'(FLUSH_CYCLES - 1)) begin
            state_d = RUN;
            fcnt_d  = '0;
          end else begin
            fcnt_d = fcnt_q + 1'b1;
          end
        end
      end
      default: begin
        if (mem_busy) begin
          stall_c = 1'b1;
          state_d = MWAIT;
        end else if (load_use) begin
          stall_c  = 1'b1;
          bubble_c = 1'b1;
          state_d  = LDSTALL;
        end else if (id_valid && id_redirect) begin
          state_d = FLUSH;
          fcnt_d  = '0;
        end else begin
          state_d = RUN;
        end
      end
    endcase
  end

  // Outputs are forced low while reset is asserted, even if mem_busy is high.
  assign stall     = stall_c & rst_n;
  assign bubble_ex = bubble_c & rst_n;
  assign flush_if  = flush_c & rst_n;

  always_comb begin
    sb_d = sb_q;
    if (!mem_busy) begin
      sb_d[2]       = sb_q[1];
      sb_d[1]       = sb_q[0];
      sb_d[0].valid = id_valid & ~bubble_c;
      sb_d[0].rd    = id_rd;
      sb_d[0].wr    = id_reg_write;
      sb_d[0].load  = id_is_load;
    end
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (stall && !(&stall_count_q)) stall_count_d = stall_count_q + 1'b1;
  end

  assign stall_count = stall_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_q          <= '0;
      state_q       <= RUN;
      fcnt_q        <= '0;
      stall_count_q <= '0;
    end else begin
      sb_q          <= sb_d;
      state_q       <= state_d;
      fcnt_q        <= fcnt_d;
      stall_count_q <= stall_count_d;
    end
  end

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Bench for hazard_forward_ctrl: directed vector table, reset/saturation sequences,
// then random stimulus against a pipeline-queue reference model.
module tb_hazard_forward_ctrl;
  import core_pkg::*;

  localparam int FC = 2;
  localparam int CW = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          id_valid, id_uses_a, id_uses_b, id_reg_write, id_is_load, id_redirect, mem_busy;
  logic [2:0]    id_ra, id_rb, id_rd;
  logic [1:0]    forward_a, forward_b;
  logic          stall, bubble_ex, flush_if;
  logic [CW-1:0] stall_count;

  hazard_forward_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ra(id_ra), .id_rb(id_rb),
    .id_uses_a(id_uses_a), .id_uses_b(id_uses_b), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_is_load(id_is_load), .id_redirect(id_redirect),
    .mem_busy(mem_busy), .forward_a(forward_a), .forward_b(forward_b), .stall(stall),
    .bubble_ex(bubble_ex), .flush_if(flush_if), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  typedef struct {int v, ra, rb, ua, ub, rd, rw, ld, rdir, mb;} in_t;
  typedef struct {in_t in; int fa, fb, st, bu, fl, cnt;} vec_t;
  typedef struct {bit v; int rd; bit wr; bit ld;} ent_t;

  int   checks   = 0;
  int   failures = 0;
  vec_t tbl[23];
  ent_t pipe[3];
  int   flush_left;
  int   m_cnt;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input in_t x);
    id_valid     = (x.v != 0);
    id_ra        = 3'(x.ra);
    id_rb        = 3'(x.rb);
    id_uses_a    = (x.ua != 0);
    id_uses_b    = (x.ub != 0);
    id_rd        = 3'(x.rd);
    id_reg_write = (x.rw != 0);
    id_is_load   = (x.ld != 0);
    id_redirect  = (x.rdir != 0);
    mem_busy     = (x.mb != 0);
  endtask

  // Drive one cycle's decode inputs just after the edge, return at the sampling point.
  task automatic step(input in_t x);
    @(posedge clk);
    #1;
    drive(x);
    @(negedge clk);
  endtask

  task automatic check_all(input string tag, input int fa, input int fb, input int st,
                           input int bu, input int fl, input int cnt);
    chk({tag, " forward_a"}, int'(forward_a), fa);
    chk({tag, " forward_b"}, int'(forward_b), fb);
    chk({tag, " stall"}, int'(stall), st);
    chk({tag, " bubble_ex"}, int'(bubble_ex), bu);
    chk({tag, " flush_if"}, int'(flush_if), fl);
    chk({tag, " stall_count"}, int'(stall_count), cnt);
  endtask

  // Reference model: in-flight writers as a 3-deep queue, youngest first.
  function automatic int mfwd(input int src, input bit use_it);
    for (int i = 0; i < 3; i++)
      if (pipe[i].v && pipe[i].wr && pipe[i].rd == src && src != 0 && use_it) return i + 1;
    return 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) pipe[i] = '{0, 0, 0, 0};
    flush_left = 0;
    m_cnt      = 0;
  endtask

  task automatic model_cycle(output int fa, output int fb, output int st, output int bu,
                             output int fl, output int cnt);
    bit lu;
    fa  = mfwd(int'(id_ra), id_uses_a);
    fb  = mfwd(int'(id_rb), id_uses_b);
    lu  = pipe[0].ld && (fa == 1 || fb == 1);
    cnt = m_cnt;
    if (flush_left > 0) begin
      fl = 1; st = int'(mem_busy); bu = 0;
      if (!mem_busy) flush_left--;
    end else begin
      fl = 0;
      st = (mem_busy || lu) ? 1 : 0;
      bu = (!mem_busy && lu) ? 1 : 0;
      if (!mem_busy && !lu && id_valid && id_redirect) flush_left = FC;
    end
    if (st != 0 && m_cnt < (1 << CW) - 1) m_cnt++;
    if (!mem_busy) begin
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = '{id_valid && bu == 0, int'(id_rd), id_reg_write, id_is_load};
    end
  endtask

  initial begin
    in_t z, x;
    int  e_fa, e_fb, e_st, e_bu, e_fl, e_cnt;
    z = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

    //            v ra rb ua ub rd rw ld rdir mb    fa fb st bu fl cnt
    tbl[0]  = '{'{1, 2, 3, 1, 1, 1, 1, 0, 0, 0},   0, 0, 0, 0, 0, 0}; // ADD R1
    tbl[1]  = '{'{1, 1, 3, 1, 1, 2, 1, 0, 0, 0},   1, 0, 0, 0, 0, 0}; // SUB R2,R1,R3
    tbl[2]  = '{'{1, 1, 0, 1, 1, 1, 1, 0, 0, 0},   2, 0, 0, 0, 0, 0}; // R1 in MEM, R0
    tbl[3]  = '{'{1, 1, 2, 1, 1, 0, 0, 0, 0, 0},   1, 2, 0, 0, 0, 0}; // R1 in EX and WB
    tbl[4]  = '{'{0, 2, 0, 1, 1, 0, 0, 0, 0, 0},   3, 0, 0, 0, 0, 0}; // R2 in WB
    tbl[5]  = '{'{1, 1, 0, 1, 0, 4, 1, 1, 0, 0},   3, 0, 0, 0, 0, 0}; // LW R4
    tbl[6]  = '{'{1, 4, 4, 1, 1, 5, 1, 0, 0, 0},   1, 1, 1, 1, 0, 0}; // ADD R5,R4,R4
    tbl[7]  = '{'{1, 4, 4, 1, 1, 5, 1, 0, 0, 0},   2, 2, 0, 0, 0, 1}; // retry
    tbl[8]  = '{'{1, 0, 0, 0, 0, 0, 0, 0, 1, 0},   0, 0, 0, 0, 0, 1}; // jump
    tbl[9]  = '{'{1, 5, 0, 1, 0, 0, 0, 0, 1, 0},   2, 0, 0, 0, 1, 1}; // flush 1
    tbl[10] = '{'{0, 5, 0, 1, 0, 0, 0, 0, 0, 0},   3, 0, 0, 0, 1, 1}; // flush 2
    tbl[11] = '{'{1, 0, 0, 0, 0, 6, 1, 0, 0, 0},   0, 0, 0, 0, 0, 1}; // write R6
    tbl[12] = '{'{1, 6, 0, 1, 0, 0, 0, 0, 0, 1},   1, 0, 1, 0, 0, 1}; // mem wait
    tbl[13] = '{'{1, 6, 0, 1, 0, 0, 0, 0, 0, 1},   1, 0, 1, 0, 0, 2};
    tbl[14] = '{'{1, 6, 0, 1, 0, 0, 0, 0, 0, 1},   1, 0, 1, 0, 0, 3};
    tbl[15] = '{'{1, 6, 0, 1, 0, 0, 0, 0, 0, 0},   1, 0, 0, 0, 0, 4}; // frozen, releases
    tbl[16] = '{'{0, 6, 0, 1, 0, 0, 0, 0, 0, 0},   2, 0, 0, 0, 0, 4};
    tbl[17] = '{'{1, 0, 0, 0, 0, 3, 1, 1, 0, 0},   0, 0, 0, 0, 0, 4}; // LW R3
    tbl[18] = '{'{1, 0, 3, 0, 1, 0, 0, 0, 1, 0},   0, 1, 1, 1, 0, 4}; // branch on R3
    tbl[19] = '{'{1, 0, 3, 0, 1, 0, 0, 0, 1, 0},   0, 2, 0, 0, 0, 5}; // retry redirects
    tbl[20] = '{z, 0, 0, 0, 0, 1, 5};
    tbl[21] = '{z, 0, 0, 0, 0, 1, 5};
    tbl[22] = '{z, 0, 0, 0, 0, 0, 5};

    rst_n = 1'b0;
    drive(z);
    mem_busy = 1'b1;
    #12;
    check_all("reset", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n    = 1'b1;
    mem_busy = 1'b0;

    for (int i = 0; i < 23; i++) begin
      step(tbl[i].in);
      check_all($sformatf("row%0d", i), tbl[i].fa, tbl[i].fb, tbl[i].st, tbl[i].bu,
                tbl[i].fl, tbl[i].cnt);
    end

    // Reset asserted mid-flush with mem_busy high.
    step('{1, 0, 0, 0, 0, 3, 1, 0, 0, 0});
    step('{1, 3, 0, 1, 0, 0, 0, 0, 1, 0});
    chk("pre-flush forward_a", int'(forward_a), 1);
    step('{0, 3, 0, 1, 0, 0, 0, 0, 0, 0});
    chk("flush active", int'(flush_if), 1);
    chk("flush forward_a", int'(forward_a), 2);
    mem_busy = 1'b1;
    rst_n    = 1'b0;
    #1;
    check_all("mid-flush reset", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    drive(z);
    rst_n = 1'b1;
    step(z);
    chk("no residual flush", int'(flush_if), 0);
    chk("no residual stall", int'(stall), 0);

    // Stall counter saturates at all-ones and does not wrap.
    x = z;
    x.mb = 1;
    for (int i = 0; i < 70; i++) step(x);
    chk("sat stall", int'(stall), 1);
    chk("sat count", int'(stall_count), (1 << CW) - 1);
    step(z);
    chk("sat hold", int'(stall_count), (1 << CW) - 1);

    // Random traffic against the reference model.
    rst_n = 1'b0;
    #3;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 1500; n++) begin
      x.v    = ($urandom_range(0, 99) < 85) ? 1 : 0;
      x.ra   = $urandom_range(0, 7);
      x.rb   = $urandom_range(0, 7);
      x.ua   = $urandom_range(0, 1);
      x.ub   = $urandom_range(0, 1);
      x.rd   = $urandom_range(0, 7);
      x.rw   = ($urandom_range(0, 99) < 70) ? 1 : 0;
      x.ld   = ($urandom_range(0, 99) < 30) ? 1 : 0;
      x.rdir = ($urandom_range(0, 99) < 10) ? 1 : 0;
      x.mb   = ($urandom_range(0, 99) < 15) ? 1 : 0;
      step(x);
      model_cycle(e_fa, e_fb, e_st, e_bu, e_fl, e_cnt);
      check_all($sformatf("rand%0d", n), e_fa, e_fb, e_st, e_bu, e_fl, e_cnt);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
